// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Operand-forwarding scoreboard for an in-order pipeline. Remembers the
//   destination of each instruction in the DEPTH stages after EX (stage 1 =
//   MEM, stage 2 = WB, ...). For every EX source operand it reports which stage
//   holds the youngest producer. It raises a load-use stall when that producer's
//   result is not forwardable yet.
//
//   Optional feature: define FWD_SCOREBOARD_CSR_EN to track CSR writers and drive
//   csr_fwd_sel. Without it, CSR inputs are ignored and csr_fwd_sel reads 0.
//
//   Pipeline movement: advance=1 shifts the table one stage on the rising edge.
//   While stall=1, the EX instruction is held upstream and a bubble is entered
//   in its place. There is no valid/ready handshake on this block.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   advance           pipeline moves one stage this cycle
//   flush             EX instruction is killed and does not enter stage 1
//   issue_we/rd/late  EX destination write enable, register, late (load) result
//   rs_addr           EX source registers, operand i at [5i+4:5i]
//   issue_csr_we/addr EX CSR write enable and address (CSR build only)
//   fwd_sel           per operand: 0 = register file, k = stage k result
//   csr_fwd_sel       0 = CSR file, k = stage k CSR result
//   stall             hold IF/ID/EX and insert a bubble into stage 1
//   stall_cnt         saturating count of cycles with stall=1
module fwd_scoreboard #(
  parameter  int NUM_SRC          = 2,
  parameter  int DEPTH            = 2,
  parameter  int LOAD_READY_STAGE = 2,
  parameter  int CNT_W            = 16,
  localparam int SEL_W            = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     issue_we,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_late,
  input  logic [NUM_SRC*5-1:0]     rs_addr,
  input  logic                     issue_csr_we,
  input  logic [11:0]              issue_csr_addr,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [SEL_W-1:0]         csr_fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Table entries are indexed by stage number, 1 = youngest.
  logic [DEPTH:1]           r_valid;
  logic [DEPTH:1]           r_we;
  logic [DEPTH:1]           r_late;
  logic [4:0]               r_rd [1:DEPTH];
  logic [CNT_W-1:0]         r_stall_cnt;

  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic [NUM_SRC-1:0]       w_not_ready;
  logic                     w_stall;
  logic                     w_enter;
  logic [SEL_W-1:0]         w_csr_sel;

  // Scan from the oldest stage down to the youngest. A later (younger) match
  // overwrites an earlier one, so the youngest producer wins. The ready check
  // uses only the winner, so an older ready copy cannot hide a load-use hazard.
  always_comb begin
    w_fwd_sel   = '0;
    w_not_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_valid[k] && r_we[k] && (r_rd[k] != 5'd0) &&
            (r_rd[k] == rs_addr[5*i +: 5])) begin
          w_fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(k);
          w_not_ready[i]              = r_late[k] && (k < LOAD_READY_STAGE);
        end
      end
    end
  end

  assign w_stall = |w_not_ready;
  // A stalled or flushed EX instruction becomes a bubble in stage 1.
  assign w_enter = !w_stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_we    <= '0;
      r_late  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_rd[k] <= '0;
      end
    end else if (advance) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_we[k]    <= r_we[k-1];
        r_late[k]  <= r_late[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      r_valid[1] <= w_enter;
      r_we[1]    <= issue_we;
      r_late[1]  <= issue_late;
      r_rd[1]    <= issue_rd;
    end
  end

  // Counts every stalled edge, including edges where the table is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

`ifdef FWD_SCOREBOARD_CSR_EN
  logic [DEPTH:1] r_csr_we;
  logic [11:0]    r_csr_addr [1:DEPTH];

  // CSR results are produced early, so a CSR match never stalls.
  // CSR address 0 is a legal CSR address.
  always_comb begin
    w_csr_sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (r_valid[k] && r_csr_we[k] && (r_csr_addr[k] == issue_csr_addr)) begin
        w_csr_sel = SEL_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csr_we <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_csr_addr[k] <= '0;
      end
    end else if (advance) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_csr_we[k]   <= r_csr_we[k-1];
        r_csr_addr[k] <= r_csr_addr[k-1];
      end
      r_csr_we[1]   <= issue_csr_we;
      r_csr_addr[1] <= issue_csr_addr;
    end
  end
`else
  assign w_csr_sel = '0;
  // CSR inputs are intentionally unused in this build.
  logic w_unused_csr;
  assign w_unused_csr = ^{issue_csr_we, issue_csr_addr};
`endif

  assign fwd_sel     = w_fwd_sel;
  assign csr_fwd_sel = w_csr_sel;
  assign stall       = w_stall;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int LRS     = 2;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EXP_W   = NUM_SRC*SEL_W + 1 + SEL_W;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     advance = 1'b0;
  logic                     flush = 1'b0;
  logic                     issue_we = 1'b0;
  logic [4:0]               issue_rd = '0;
  logic                     issue_late = 1'b0;
  logic [NUM_SRC*5-1:0]     rs_addr = '0;
  logic                     issue_csr_we = 1'b0;
  logic [11:0]              issue_csr_addr = '0;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [SEL_W-1:0]         csr_fwd_sel;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_READY_STAGE(LRS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .issue_we(issue_we), .issue_rd(issue_rd), .issue_late(issue_late),
    .rs_addr(rs_addr), .issue_csr_we(issue_csr_we), .issue_csr_addr(issue_csr_addr),
    .fwd_sel(fwd_sel), .csr_fwd_sel(csr_fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  // ---------------- reference model ----------------
  // Pipe of in-flight instructions; element 0 is stage 1 (youngest).
  typedef struct {
    bit       valid;
    bit       we;
    bit [4:0] rd;
    bit       late;
    bit       csr_we;
    bit [11:0] csr_addr;
  } instr_t;

  instr_t pipe[$];
  int     m_cnt;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.we = 0; b.rd = 0; b.late = 0; b.csr_we = 0; b.csr_addr = 0;
    return b;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back(bubble());
    m_cnt = 0;
  endtask

  // Expected outputs packed as {csr_sel, stall, fwd_sel}.
  function automatic logic [EXP_W-1:0] model_eval();
    logic [NUM_SRC*SEL_W-1:0] sels;
    logic                     st;
    logic [SEL_W-1:0]         csel;
    sels = '0; st = 1'b0; csel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bit [4:0] src;
      bit found;
      src = rs_addr[5*i +: 5];
      found = 0;
      for (int s = 0; s < DEPTH; s++) begin
        if (!found && src != 0 && pipe[s].valid && pipe[s].we && pipe[s].rd == src) begin
          found = 1;
          sels[SEL_W*i +: SEL_W] = SEL_W'(s + 1);
          if (pipe[s].late && (s + 1) < LRS) st = 1'b1;
        end
      end
    end
`ifdef FWD_SCOREBOARD_CSR_EN
    begin
      bit cfound;
      cfound = 0;
      for (int s = 0; s < DEPTH; s++) begin
        if (!cfound && pipe[s].valid && pipe[s].csr_we && pipe[s].csr_addr == issue_csr_addr) begin
          cfound = 1;
          csel = SEL_W'(s + 1);
        end
      end
    end
`endif
    return {csel, st, sels};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_check();
    logic [EXP_W-1:0] e;
    exp_q.push_back(model_eval());
    e = exp_q.pop_front();
    check("fwd_sel",     32'(fwd_sel),     32'(e[NUM_SRC*SEL_W-1:0]));
    check("stall",       32'(stall),       32'(e[NUM_SRC*SEL_W]));
    check("csr_fwd_sel", 32'(csr_fwd_sel), 32'(e[EXP_W-1 -: SEL_W]));
    check("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: apply inputs, settle, compare.
  task automatic drive(input logic adv, input logic fl, input logic we,
                       input logic [4:0] rd, input logic late,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic cwe, input logic [11:0] ca);
    advance = adv; flush = fl; issue_we = we; issue_rd = rd; issue_late = late;
    rs_addr = {r1, r0}; issue_csr_we = cwe; issue_csr_addr = ca;
    #1;
    model_check();
  endtask

  // Cross one rising edge and update the model with the same inputs.
  task automatic tick();
    logic st;
    logic [EXP_W-1:0] e;
    e  = model_eval();
    st = e[NUM_SRC*SEL_W];
    @(posedge clk);
    if (rst_n) begin
      if (st && m_cnt != CNT_MAX) m_cnt++;
      if (advance) begin
        instr_t n;
        if (st || flush) n = bubble();
        else begin
          n.valid = 1; n.we = issue_we; n.rd = issue_rd; n.late = issue_late;
          n.csr_we = issue_csr_we; n.csr_addr = issue_csr_addr;
        end
        pipe.push_front(n);
        void'(pipe.pop_back());
      end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    model_check();
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU chain: producer in stage 1, then 2, then gone.
    drive(1, 0, 1, 5'd5, 0, 5'd0, 5'd0, 0, 12'h0); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd5, 5'd0, 0, 12'h0);
    check("alu_stage1", 32'(fwd_sel[1:0]), 32'd1); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd5, 5'd0, 0, 12'h0);
    check("alu_stage2", 32'(fwd_sel[1:0]), 32'd2); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd5, 5'd0, 0, 12'h0);
    check("alu_gone", 32'(fwd_sel[1:0]), 32'd0); tick();

    // Load-use: exactly one stall cycle, then forward from stage 2.
    drive(1, 0, 1, 5'd7, 1, 5'd0, 5'd0, 0, 12'h0); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd0, 5'd7, 0, 12'h0);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_cnt0", 32'(stall_cnt), 32'd0); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd0, 5'd7, 0, 12'h0);
    check("lu_nostall", 32'(stall), 32'd0);
    check("lu_sel2", 32'(fwd_sel[3:2]), 32'd2);
    check("lu_cnt1", 32'(stall_cnt), 32'd1); tick();

    // Priority (youngest wins) and x0 never forwarding.
    drive(1, 0, 1, 5'd3, 0, 5'd0, 5'd0, 0, 12'h0); tick();
    drive(1, 0, 1, 5'd3, 0, 5'd0, 5'd0, 0, 12'h0); tick();
    drive(1, 0, 1, 5'd0, 0, 5'd3, 5'd0, 0, 12'h0);
    check("prio_s1", 32'(fwd_sel[1:0]), 32'd1); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd0, 5'd3, 0, 12'h0);
    check("x0_sel", 32'(fwd_sel[1:0]), 32'd0);
    check("older_s2", 32'(fwd_sel[3:2]), 32'd2); tick();

    // Flush: killed instruction is never a producer.
    drive(1, 1, 1, 5'd9, 0, 5'd0, 5'd0, 0, 12'h0); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd9, 5'd0, 0, 12'h0);
    check("flush_sel", 32'(fwd_sel[1:0]), 32'd0); tick();

    // CSR forwarding from stage 2.
    drive(1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 1, 12'h300); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 12'h000); tick();
    drive(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 12'h300);
`ifdef FWD_SCOREBOARD_CSR_EN
    check("csr_sel", 32'(csr_fwd_sel), 32'd2);
`else
    check("csr_sel", 32'(csr_fwd_sel), 32'd0);
`endif
    check("csr_nostall", 32'(stall), 32'd0); tick();

    // Stall with advance=0 holds; counter saturates.
    drive(1, 0, 1, 5'd12, 1, 5'd0, 5'd0, 0, 12'h0); tick();
    drive(0, 0, 0, 5'd0, 0, 5'd12, 5'd0, 0, 12'h0); tick();
    drive(0, 0, 0, 5'd0, 0, 5'd12, 5'd0, 0, 12'h0);
    check("hold_stall", 32'(stall), 32'd1);
    for (int n = 0; n < 18; n++) begin
      tick();
      drive(0, 0, 0, 5'd0, 0, 5'd12, 5'd0, 0, 12'h0);
    end
    check("cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
    check("hold_stall_long", 32'(stall), 32'd1);
    drive(1, 0, 0, 5'd0, 0, 5'd12, 5'd0, 0, 12'h0); tick();
    drive(1, 0, 0, 5'd0, 0, 5'd12, 5'd0, 0, 12'h0);
    check("release_stall", 32'(stall), 32'd0);
    check("release_sel", 32'(fwd_sel[1:0]), 32'd2); tick();

    // Reset in the middle of a load-use stall.
    drive(1, 0, 1, 5'd10, 1, 5'd0, 5'd0, 0, 12'h0); tick();
    drive(0, 0, 0, 5'd0, 0, 5'd10, 5'd10, 0, 12'h0);
    check("pre_rst_stall", 32'(stall), 32'd1); tick();
    rst_n = 1'b0;
    #1;
    check("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    model_check();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 5'd0, 0, 5'd10, 5'd10, 0, 12'h0);
    check("post_rst_stall", 32'(stall), 32'd0); tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            12'($urandom_range(0, 2)));
      tick();
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
